// File: rtl/instr_mem_loader.sv
// instr_mem_loader: parses a length-prefixed, checksummed byte stream into instruction-memory word writes.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, DATA = 3'd3,
                         CHECK = 3'd4, DONE = 3'd5, ERR = 3'd6;
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d, idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  csum_q, csum_d;
  logic [23:0] word_q, word_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic        acc, restart;
  logic [15:0] n;
  assign byte_ready = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};
  assign busy       = byte_ready;
  assign done       = state_q == DONE;
  assign error      = state_q == ERR;
  assign cpu_hold   = !(state_q inside {IDLE, DONE});
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign acc        = byte_valid && byte_ready;
  assign restart    = start && state_q inside {IDLE, DONE, ERR};
  assign n          = {byte_data, len_q[7:0]};
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    csum_d    = csum_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (restart) begin
      state_d = LEN_LO;
      idx_d   = '0;
      lane_d  = '0;
      csum_d  = '0;
      word_d  = '0;
    end else if (acc) begin
      case (state_q)
        LEN_LO: begin
          len_d[7:0] = byte_data;
          state_d    = LEN_HI;
        end
        LEN_HI: begin
          len_d   = n;
          state_d = n == 16'd0 ? CHECK : ({1'b0, n} > MAXW) ? ERR : DATA;
        end
        DATA: begin
          // bytes arrive LSB first, so shift each new byte in from the top
          lane_d = lane_q + 2'd1;
          csum_d = csum_q ^ byte_data;
          word_d = {byte_data, word_q[23:8]};
          if (lane_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
            wr_data_d = {byte_data, word_q};
            idx_d     = idx_q + 16'd1;
            state_d   = idx_q == len_q - 16'd1 ? CHECK : DATA;
          end
        end
        CHECK: state_d = byte_data == csum_q ? DONE : ERR;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      lane_q    <= '0;
      csum_q    <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      csum_q    <= csum_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench; expected writes are queued at stimulus time and a negedge monitor pops them.
module tb_instr_mem_loader;
  localparam int MAXW = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic clk = 0, rst_n = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, wr_en, cpu_hold, busy, done, error;
  logic [31:0] wr_addr, wr_data;
  logic [63:0] exp_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && wr_en) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL wr_unexpected: got %h/%h expected no write", wr_addr, wr_data);
    end else chk("wr addr/data", {wr_addr, wr_data}, exp_q.pop_front());
  end
  // Reference: parse the stream by its format rules and queue every word write it implies.
  task automatic model(input logic [7:0] s[$], output int st);
    int n;
    logic [7:0] x;
    st = 0;
    x = 0;
    if (s.size() < 2) return;
    n = int'({s[1], s[0]});
    if (n > MAXW) begin
      st = 2;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (s.size() < 6 + 4 * w) return;
      exp_q.push_back({BASE + 32'(4 * w), s[5+4*w], s[4+4*w], s[3+4*w], s[2+4*w]});
      x ^= s[2+4*w] ^ s[3+4*w] ^ s[4+4*w] ^ s[5+4*w];
    end
    if (s.size() < 3 + 4 * n) return;
    st = s[2+4*n] == x ? 1 : 2;
  endtask
  task automatic send(input logic [7:0] s[$], input bit rnd, input int start_at);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    foreach (s[i]) begin
      if (rnd) while ($urandom_range(0, 2) == 0) begin
        byte_valid = 0;
        byte_data = 8'($urandom);
        @(posedge clk); #1;
      end
      byte_valid = 1;
      byte_data = s[i];
      start = (i == start_at);
      chk("byte_ready", byte_ready, 1);
      @(posedge clk); #1;
    end
    byte_valid = 0;
    start = 0;
  endtask
  task automatic run(input string nm, input logic [7:0] s[$], input bit rnd, input int start_at, input int st);
    send(s, rnd, start_at);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " drain"}, 64'(exp_q.size()), 0);
    chk({nm, " done"}, done, st == 1);
    chk({nm, " error"}, error, st == 2);
    chk({nm, " cpu_hold"}, cpu_hold, st != 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " ready"}, byte_ready, 0);
    exp_q.delete();
  endtask
  task automatic outs_zero(input string nm);
    chk({nm, " outs"}, {byte_ready, wr_en, busy, done, error, cpu_hold}, 0);
    chk({nm, " addr/data"}, {wr_addr, wr_data}, 0);
  endtask
  initial begin
    logic [7:0] good[$], s[$];
    logic [7:0] x;
    int st, n;
    good = '{8'h02, 8'h00, 8'h37, 8'h13, 8'h90, 8'h01, 8'h37, 8'h06, 8'h19, 8'h00, 8'h9D};
    #3 outs_zero("reset");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    outs_zero("idle");
    exp_q.push_back({32'h0, 32'h0190_1337});
    exp_q.push_back({32'h4, 32'h0019_0637});
    run("good", good, 0, -1, 1);
    s = good;
    s[10] = 8'h9C;
    exp_q.push_back({32'h0, 32'h0190_1337});
    exp_q.push_back({32'h4, 32'h0019_0637});
    run("badsum", s, 0, -1, 2);
    run("toolong", '{8'h41, 8'h00}, 0, -1, 2);
    run("empty", '{8'h00, 8'h00, 8'h00}, 0, -1, 1);
    run("emptybad", '{8'h00, 8'h00, 8'h01}, 0, -1, 2);
    exp_q.push_back({32'h0, 32'h0190_1337});
    exp_q.push_back({32'h4, 32'h0019_0637});
    run("rndvalid_start", good, 1, 5, 1);
    s = good[0:7];
    exp_q.push_back({32'h0, 32'h0190_1337});
    send(s, 0, -1);
    chk("prerst drain", 64'(exp_q.size()), 0);
    #3 rst_n = 0;
    #1 outs_zero("async rst");
    @(posedge clk); #1;
    outs_zero("rst held");
    rst_n = 1;
    @(posedge clk); #1;
    exp_q.push_back({32'h0, 32'h0190_1337});
    exp_q.push_back({32'h4, 32'h0019_0637});
    run("after_rst", good, 0, -1, 1);
    for (int t = 0; t < 10; t++) begin
      n = t == 8 ? MAXW : t == 9 ? MAXW + 1 : $urandom_range(0, 6);
      s = {};
      s.push_back(n[7:0]);
      s.push_back(n[15:8]);
      if (n <= MAXW) begin
        x = 0;
        for (int i = 0; i < 4 * n; i++) begin
          s.push_back(8'($urandom));
          x ^= s[2+i];
        end
        s.push_back($urandom_range(0, 3) == 0 ? x ^ 8'h5A : x);
      end
      model(s, st);
      run($sformatf("rand%0d", t), s, t[0], -1, st);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00000000, the byte address of the first instruction word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 64, the largest accepted word count (1..65535).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, one-cycle request to begin a load.
REQ-006 The block SHALL have port byte_valid, input, 1, which marks byte_data as valid.
REQ-007 The block SHALL have port byte_data, input, 8, the serial program byte.
REQ-008 The block SHALL have port byte_ready, output, 1, which marks that the loader accepts a byte this cycle.
REQ-009 The block SHALL have port wr_en, output, 1, the instruction-memory write strobe.
REQ-010 The block SHALL have port wr_addr, output, 32, the instruction-memory byte address (word-aligned).
REQ-011 The block SHALL have port wr_data, output, 32, the instruction word.
REQ-012 The block SHALL have port cpu_hold, output, 1, which holds the processor PC and fetch off while the load is in progress.
REQ-013 The block SHALL have ports busy, done and error, outputs, 1 each, giving load status.

Function
REQ-014 A byte SHALL be accepted only in a cycle where byte_valid and byte_ready are both 1; byte_valid without byte_ready SHALL have no effect.
REQ-015 The stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N), then N words of 4 bytes each, least-significant byte first, then one checksum byte.
REQ-016 The state machine SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE and ERR.
REQ-017 IDLE, DONE and ERR SHALL move to LEN_LO on start; start SHALL be ignored in every other state.
REQ-018 LEN_LO SHALL move to LEN_HI on an accepted byte.
REQ-019 LEN_HI SHALL move on an accepted byte as follows: N==0 -> CHECK; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-020 DATA SHALL collect the bytes into a word; after the 4th byte of word i, wr_en SHALL be 1 for exactly the next cycle, with wr_addr = BASE_ADDR + 4*i and wr_data equal to the assembled word.
REQ-021 DATA SHALL move to CHECK after the 4th byte of word N-1.
REQ-022 Back-to-back bytes with byte_valid held at 1 SHALL be accepted at one per cycle; byte_ready SHALL stay 1 in the cycle of the wr_en pulse.
REQ-023 The checksum SHALL be the XOR of all data bytes (length bytes excluded; 8'h00 when N==0).
REQ-024 CHECK SHALL move on an accepted byte: byte equals checksum -> DONE; otherwise -> ERR.
REQ-025 byte_ready SHALL be 1 only in LEN_LO, LEN_HI, DATA and CHECK.
REQ-026 busy SHALL be 1 in LEN_LO, LEN_HI, DATA and CHECK.
REQ-027 done SHALL be 1 only in DONE; error SHALL be 1 only in ERR; both SHALL stay set until the next start or reset.
REQ-028 cpu_hold SHALL be 1 in every state except IDLE and DONE, so an erroneous image never runs.
REQ-029 The word index and the address arithmetic SHALL be 16-bit and 32-bit unsigned respectively, with no wrap before N words.
REQ-030 The byte lane counter, word index and checksum SHALL be cleared on every transition into LEN_LO.

Reset
REQ-031 When rst_n = 0, the block SHALL, asynchronously, enter IDLE and clear all counters, the checksum and the word register.
REQ-032 During reset, byte_ready, wr_en, busy, done, error and cpu_hold SHALL be 0, and wr_addr and wr_data SHALL be 0.
REQ-033 A reset asserted mid-load SHALL abort the load with no further wr_en, and SHALL not depend on clk.

Verification
REQ-034 Bench: start, then bytes 02 00 37 13 90 01 37 06 19 00 9D -> wr_en at addr 0x0 with data 0x01901337, then at addr 0x4 with data 0x00190637; ends with done=1, cpu_hold=0.
REQ-035 Bench: same stream with the last byte 9C -> both writes occur; then error=1, cpu_hold=1, done=0.
REQ-036 Bench: length bytes 41 00 with MAX_WORDS=64 -> ERR after the second byte; no wr_en.
REQ-037 Bench: length bytes 00 00 then checksum 00 -> DONE with no wr_en; length bytes 00 00 then 01 -> ERR.
REQ-038 Bench: byte_valid toggled randomly, and start pulsed during DATA -> same writes as REQ-034; the start has no effect.
REQ-039 Bench: rst_n pulsed low between clock edges after 6 data bytes -> all outputs 0 at once; a new load afterwards writes from BASE_ADDR again.
